// File: rtl/yin_cmnd_feed.sv
// CMND operand feed: forms dividend d(tau)*tau and divisor sum(d(1..tau)) and issues them to the divider.
// Optional YIN_CMND_CLAMP_EN clamps the dividend to 2*divisor-1 so the quotient stays below 2.0.
module yin_cmnd_feed #(
  parameter int WIDTH          = 42,
  parameter int FRACTION_WIDTH = 10,
  parameter int TAU_WIDTH      = 11
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [WIDTH-FRACTION_WIDTH-1:0]     diff_in,
  input  logic                                diff_first_in,
  input  logic                                diff_valid_in,
  output logic                                diff_ready_out,
  output logic [WIDTH-FRACTION_WIDTH-1:0]     div_dividend_out,
  output logic [WIDTH-FRACTION_WIDTH-1:0]     div_divisor_out,
  output logic                                div_valid_out,
  input  logic                                div_busy_in,
  output logic [TAU_WIDTH-1:0]                tau_out
);

  localparam int DW = WIDTH - FRACTION_WIDTH;
  localparam int PW = DW + TAU_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        sum_q, sum_d;
  logic [DW-1:0]        diff_q, diff_d;
  logic [DW-1:0]        dvd_q, dvd_d;
  logic [DW-1:0]        dvs_q, dvs_d;
  logic [TAU_WIDTH-1:0] tau_cnt_q, tau_cnt_d;
  logic [TAU_WIDTH-1:0] tau_lat_q, tau_lat_d;
  logic [TAU_WIDTH-1:0] tau_out_q, tau_out_d;

  logic [DW:0]          sum_ext;
  logic [DW-1:0]        sum_sat;
  logic [PW-1:0]        prod_full;
  logic [DW-1:0]        prod_sat;
  logic [DW-1:0]        dvd_final;
  logic [TAU_WIDTH-1:0] tau_cnt_inc;

  assign sum_ext     = {1'b0, sum_q} + {1'b0, diff_in};
  assign sum_sat     = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
  assign prod_full   = {{TAU_WIDTH{1'b0}}, diff_q} * {{DW{1'b0}}, tau_lat_q};
  assign prod_sat    = (|prod_full[PW-1:DW]) ? '1 : prod_full[DW-1:0];
  assign tau_cnt_inc = (&tau_cnt_q) ? tau_cnt_q : tau_cnt_q + TAU_WIDTH'(1);

`ifdef YIN_CMND_CLAMP_EN
  // 2*divisor needs DW+1 bits; the clamped result always fits back into DW bits.
  logic [DW:0] twice_dvs;
  assign twice_dvs = {sum_q, 1'b0};
  assign dvd_final = ((sum_q != '0) && ({1'b0, prod_sat} >= twice_dvs))
                     ? DW'(twice_dvs - (DW+1)'(1)) : prod_sat;
`else
  assign dvd_final = prod_sat;
`endif

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    diff_d         = diff_q;
    dvd_d          = dvd_q;
    dvs_d          = dvs_q;
    tau_cnt_d      = tau_cnt_q;
    tau_lat_d      = tau_lat_q;
    tau_out_d      = tau_out_q;
    diff_ready_out = 1'b0;
    div_valid_out  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        diff_ready_out = 1'b1;
        if (diff_valid_in) begin
          // tau=0 has d'(0)=1 by definition, so it only restarts the frame.
          if (diff_first_in) begin
            sum_d     = '0;
            tau_cnt_d = TAU_WIDTH'(1);
          end else begin
            sum_d     = sum_sat;
            diff_d    = diff_in;
            tau_lat_d = tau_cnt_q;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        dvd_d   = dvd_final;
        dvs_d   = sum_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        div_valid_out = 1'b1;
        // Leaving ISSUE on the issue edge guarantees a single divider start per pair.
        if (!div_busy_in) begin
          tau_out_d = tau_lat_q;
          tau_cnt_d = tau_cnt_inc;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      diff_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      tau_cnt_q <= '0;
      tau_lat_q <= '0;
      tau_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      diff_q    <= diff_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      tau_cnt_q <= tau_cnt_d;
      tau_lat_q <= tau_lat_d;
      tau_out_q <= tau_out_d;
    end
  end

  assign div_dividend_out = dvd_q;
  assign div_divisor_out  = dvs_q;
  assign tau_out          = tau_out_q;

endmodule

// File: tb/tb_yin_cmnd_feed.sv
// Randomised bench for yin_cmnd_feed against a frame-level CMND operand model; YIN_CMND_CLAMP_EN selects clamp expectations.
module tb_yin_cmnd_feed;
  localparam int DW = 32;
  localparam int TW = 11;
  localparam longint unsigned DMAX = 64'hFFFF_FFFF;
  localparam longint unsigned TMAX = 64'd2047;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in        = 1'b1;
  logic [DW-1:0] diff_in       = '0;
  logic          diff_first_in = 1'b0;
  logic          diff_valid_in = 1'b0;
  logic          div_busy_in   = 1'b0;
  logic          diff_ready_out;
  logic [DW-1:0] div_dividend_out;
  logic [DW-1:0] div_divisor_out;
  logic          div_valid_out;
  logic [TW-1:0] tau_out;

  yin_cmnd_feed dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .diff_in          (diff_in),
    .diff_first_in    (diff_first_in),
    .diff_valid_in    (diff_valid_in),
    .diff_ready_out   (diff_ready_out),
    .div_dividend_out (div_dividend_out),
    .div_divisor_out  (div_divisor_out),
    .div_valid_out    (div_valid_out),
    .div_busy_in      (div_busy_in),
    .tau_out          (tau_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-frame arithmetic on the accepted sample stream.
  longint unsigned m_sum = 0, m_tau = 0;
  longint unsigned e_dvd = 0, e_dvs = 0, e_tau_pend = 0, e_tau_out = 0;
  bit              m_inflight = 1'b0;
  int              cyc = 0, acc_cyc = 0;
  longint unsigned log_dvd[$], log_dvs[$];
  bit              force_busy = 1'b0, rand_busy = 1'b0;

  task automatic model_accept(input bit first, input longint unsigned d);
    longint unsigned p;
    if (first) begin
      m_sum = 0;
      m_tau = 1;
    end else begin
      m_sum = m_sum + d;
      if (m_sum > DMAX) m_sum = DMAX;
      p = d * m_tau;
      if (p > DMAX) p = DMAX;
`ifdef YIN_CMND_CLAMP_EN
      if (m_sum != 0 && p >= 2 * m_sum) p = 2 * m_sum - 1;
`endif
      e_dvd      = p;
      e_dvs      = m_sum;
      e_tau_pend = m_tau;
      m_inflight = 1'b1;
      acc_cyc    = cyc;
      if (m_tau < TMAX) m_tau = m_tau + 1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_in) begin
      m_sum = 0; m_tau = 0; e_tau_out = 0; m_inflight = 1'b0;
    end else begin
      chk("ready", diff_ready_out, !m_inflight);
      chk("valid", div_valid_out, m_inflight && (cyc >= acc_cyc + 2));
      chk("tau_out", tau_out, e_tau_out);
      if (m_inflight && (cyc >= acc_cyc + 2)) begin
        chk("dividend", div_dividend_out, e_dvd);
        chk("divisor", div_divisor_out, e_dvs);
        if (!div_busy_in) begin
          log_dvd.push_back(div_dividend_out);
          log_dvs.push_back(div_divisor_out);
          e_tau_out  = e_tau_pend;
          m_inflight = 1'b0;
        end
      end else if (diff_valid_in && !m_inflight) begin
        model_accept(diff_first_in, diff_in);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (force_busy)     div_busy_in = 1'b1;
    else if (rand_busy) div_busy_in = ($urandom_range(0, 2) == 0);
    else                div_busy_in = 1'b0;
  end

  task automatic send(input bit first, input logic [DW-1:0] d);
    int w;
    @(posedge clk); #2;
    diff_valid_in = 1'b1; diff_first_in = first; diff_in = d;
    w = 0;
    forever begin
      @(negedge clk);
      if (diff_ready_out) break;
      w++;
      if (w > 300) begin chk("send_tmo", diff_ready_out, 1); break; end
    end
    @(posedge clk); #2;
    diff_valid_in = 1'b0; diff_first_in = 1'b0; diff_in = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (m_inflight) begin
      @(negedge clk);
      w++;
      if (w > 300) begin chk("idle_tmo", div_valid_out, 0); break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!div_valid_out) begin
      @(negedge clk);
      w++;
      if (w > 20) begin chk(tag, div_valid_out, 1); break; end
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input longint unsigned dvd, input longint unsigned dvs);
    chk({tag, "_cnt"}, (log_dvd.size() > idx), 1);
    if (log_dvd.size() > idx) begin
      chk({tag, "_dvd"}, log_dvd[idx], dvd);
      chk({tag, "_dvs"}, log_dvs[idx], dvs);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [DW-1:0] d;
    repeat (3) @(posedge clk);
    #2 rst_in = 1'b0;
    @(negedge clk);
    chk("rst_dvd", div_dividend_out, 0);
    chk("rst_dvs", div_divisor_out, 0);
    chk("rst_valid", div_valid_out, 0);

    // Basic frame
    log_dvd.delete(); log_dvs.delete();
    send(1, 7); send(0, 4); send(0, 2); send(0, 10);
    wait_idle();
    chk("basic_n", log_dvd.size(), 3);
    chk_log("basic0", 0, 4, 4);
    chk_log("basic1", 1, 4, 6);
    chk_log("basic2", 2, 30, 16);
    chk("basic_tau", tau_out, 3);

    // Clamp frame
    log_dvd.delete(); log_dvs.delete();
    send(1, 99); send(0, 1); send(0, 1); send(0, 5);
    wait_idle();
`ifdef YIN_CMND_CLAMP_EN
    chk_log("clamp2", 2, 13, 7);
`else
    chk_log("clamp2", 2, 15, 7);
`endif

    // Backpressure: ten busy cycles while issuing
    force_busy = 1'b1;
    send(1, 0); send(0, 9);
    wait_valid("bp_valid_tmo");
    repeat (10) @(negedge clk);
    chk("bp_ready", diff_ready_out, 0);
    chk("bp_valid", div_valid_out, 1);
    force_busy = 1'b0;
    wait_idle();

    // Zero divisor
    log_dvd.delete(); log_dvs.delete();
    send(1, 5); send(0, 0);
    wait_idle();
    chk_log("zero", 0, 0, 0);
    chk("zero_tau", tau_out, 1);

    // Saturation of sum and product
    log_dvd.delete(); log_dvs.delete();
    send(1, 0); send(0, 32'hFFFF_FFF0); send(0, 32'h20); send(0, 32'h9000_0000);
    wait_idle();
    chk_log("sat1", 1, 64'h40, DMAX);
    chk_log("sat2", 2, DMAX, DMAX);
    chk("sat_tau", tau_out, 3);

    // Reset while stalled in ISSUE, then samples before any frame start
    force_busy = 1'b1;
    send(1, 0); send(0, 8);
    wait_valid("rst_valid_tmo");
    @(posedge clk); #2 rst_in = 1'b1;
    @(posedge clk); #2 rst_in = 1'b0;
    @(negedge clk);
    chk("rstm_valid", div_valid_out, 0);
    chk("rstm_ready", diff_ready_out, 1);
    chk("rstm_tau", tau_out, 0);
    force_busy = 1'b0;
    log_dvd.delete(); log_dvs.delete();
    send(0, 5); send(1, 0); send(0, 3);
    wait_idle();
    chk_log("pre_first", 0, 0, 5);
    chk_log("post_rst", 1, 3, 3);
    chk("post_rst_tau", tau_out, 1);

    // Randomised frames with random divider occupancy
    rand_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       d = DW'($urandom_range(0, 20));
        1:       d = $urandom;
        2:       d = '0;
        default: d = 32'hFFFF_0000 | DW'($urandom_range(0, 255));
      endcase
      send(($urandom_range(0, 7) == 0), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_busy = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
